// File: rtl/shift_reg_univ_if.sv
// Command/status bundle for the universal shift register.
// The master drives the command fields; the slave returns the register state.
interface shift_reg_univ_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic [AMT_W-1:0] amt;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, d, amt, sin,
        input  q, sout_l, sout_r, busy, done
    );

    modport slave (
        input  start, mode, d, amt, sin,
        output q, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal working register: load/clear plus multi-step shifts and rotates,
// with a start/busy/done handshake around the shift-by-N commands.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    shift_reg_univ_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_CLR  = 3'd2,
        OP_SHL  = 3'd3,
        OP_SHR  = 3'd4,
        OP_ASR  = 3'd5,
        OP_ROTL = 3'd6,
        OP_ROTR = 3'd7
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Command captured at acceptance; later changes on the inputs cannot touch it.
    typedef struct packed {
        op_t              op;
        logic [AMT_W-1:0] cnt;
    } cmd_t;

    state_t           state, state_n;
    cmd_t             cmd, cmd_n;
    logic [WIDTH-1:0] q, q_n, q_step;
    logic             busy, busy_n;
    logic             done, done_n;
    op_t              mode_in;

    assign mode_in = op_t'(bus.mode);

    // One single-bit step of the latched operation; sin is taken live each step.
    always_comb begin
        q_step = q;
        case (cmd.op)
            OP_SHL:  q_step = {q[WIDTH-2:0], bus.sin};
            OP_SHR:  q_step = {bus.sin, q[WIDTH-1:1]};
            OP_ASR:  q_step = {q[WIDTH-1], q[WIDTH-1:1]};
            OP_ROTL: q_step = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROTR: q_step = {q[0], q[WIDTH-1:1]};
            default: q_step = q;
        endcase
    end

    always_comb begin
        state_n = state;
        cmd_n   = cmd;
        q_n     = q;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (mode_in)
                        OP_HOLD: done_n = 1'b1;
                        OP_LOAD: begin
                            q_n    = bus.d;
                            done_n = 1'b1;
                        end
                        OP_CLR: begin
                            q_n    = '0;
                            done_n = 1'b1;
                        end
                        default: begin
                            if (bus.amt == '0) begin
                                done_n = 1'b1;
                            end else begin
                                cmd_n.op  = mode_in;
                                cmd_n.cnt = bus.amt;
                                state_n   = SHIFT;
                                busy_n    = 1'b1;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                q_n       = q_step;
                cmd_n.cnt = cmd.cnt - AMT_W'(1);
                if (cmd.cnt == AMT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    busy_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmd   <= '{op: OP_HOLD, cnt: '0};
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cmd   <= cmd_n;
            q     <= q_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    assign bus.q      = q;
    assign bus.sout_l = q[WIDTH-1];
    assign bus.sout_r = q[0];
    assign bus.busy   = busy;
    assign bus.done   = done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: each task drives one scenario and checks
// against hand-computed values. Inputs change and outputs are sampled on negedge.
module tb_shift_reg_univ;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    shift_reg_univ_if #(.WIDTH(8), .AMT_W(4)) bus ();

    shift_reg_univ #(.WIDTH(8), .AMT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.mode  = 3'd0;
        bus.d     = 8'h00;
        bus.amt   = 4'd0;
        bus.sin   = 1'b0;
    endtask

    // Load v and stop in the cycle where the load's done pulse is visible.
    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd1; bus.d = v;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Issue a shift, then follow it to done counting busy cycles.
    task automatic run_shift(input string name, input logic [2:0] mode, input logic [3:0] amt,
                             input logic sin, input logic [7:0] q0, input logic [7:0] exp_q);
        int  nbusy;
        bit  seen;
        bit  overlap;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = mode; bus.amt = amt; bus.sin = sin;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.q !== q0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL %s_accept: busy=%b q=%h done=%b, required busy=1 q=%h done=0",
                     name, bus.busy, bus.q, bus.done, q0);
        end
        nbusy = 1; seen = 0; overlap = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy && bus.done) overlap = 1;
            if (bus.busy) nbusy++;
            if (bus.done) seen = 1;
        end
        n_cmp++;
        if (!seen || overlap) begin
            n_err++;
            $display("FAIL %s_done: seen=%b overlap=%b, required seen=1 overlap=0", name, seen, overlap);
        end
        n_cmp++;
        if (nbusy !== int'(amt)) begin
            n_err++;
            $display("FAIL %s_busy_cycles: got %0d, required %0d", name, nbusy, amt);
        end
        n_cmp++;
        if (bus.q !== exp_q) begin
            n_err++;
            $display("FAIL %s_q: got %h, required %h", name, bus.q, exp_q);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_after: done=%b busy=%b, required 0 0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset: q=%h busy=%b done=%b, required 00 0 0", bus.q, bus.busy, bus.done);
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        do_load(8'hA5);
        n_cmp++;
        if (bus.q !== 8'hA5 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL load: q=%h done=%b busy=%b, required a5 1 0", bus.q, bus.done, bus.busy);
        end
        n_cmp++;
        if (bus.sout_l !== 1'b1 || bus.sout_r !== 1'b1) begin
            n_err++;
            $display("FAIL load_sout: l=%b r=%b, required 1 1", bus.sout_l, bus.sout_r);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 8'hA5) begin
            n_err++;
            $display("FAIL load_after: done=%b busy=%b q=%h, required 0 0 a5", bus.done, bus.busy, bus.q);
        end
    endtask

    task automatic test_shl_steps();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h03; exp_q[1] = 8'h07; exp_q[2] = 8'h0F;
        do_load(8'h81);
        bus.start = 1'b1; bus.mode = 3'd3; bus.amt = 4'd3; bus.sin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.q !== 8'h81) begin
            n_err++;
            $display("FAIL shl_accept: busy=%b q=%h, required 1 81", bus.busy, bus.q);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.q !== exp_q[i] || bus.busy !== (i < 2) || bus.done !== (i == 2)) begin
                n_err++;
                $display("FAIL shl_step%0d: q=%h busy=%b done=%b, required %h %b %b",
                         i, bus.q, bus.busy, bus.done, exp_q[i], (i < 2), (i == 2));
            end
        end
        bus.sin = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL shl_done_width: done=%b, required 0", bus.done);
        end
    endtask

    task automatic test_shr();
        do_load(8'h81);
        run_shift("shr", 3'd4, 4'd2, 1'b0, 8'h81, 8'h20);
    endtask

    task automatic test_asr_rot();
        do_load(8'h90);
        n_cmp++;
        if (bus.sout_l !== 1'b1 || bus.sout_r !== 1'b0) begin
            n_err++;
            $display("FAIL sout_90: l=%b r=%b, required 1 0", bus.sout_l, bus.sout_r);
        end
        run_shift("asr", 3'd5, 4'd2, 1'b0, 8'h90, 8'hE4);
        do_load(8'h81);
        run_shift("rotl8", 3'd6, 4'd8, 1'b0, 8'h81, 8'h81);
        do_load(8'h81);
        run_shift("rotr1", 3'd7, 4'd1, 1'b0, 8'h81, 8'hC0);
    endtask

    task automatic test_back_to_back();
        bit seen;
        do_load(8'h3C);
        bus.start = 1'b1; bus.mode = 3'd3; bus.amt = 4'd4; bus.sin = 1'b0;
        @(negedge clk);
        // Clear request while busy, with different amt too: must be ignored.
        bus.mode = 3'd2; bus.amt = 4'd1; bus.d = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.done) seen = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen || bus.q !== 8'hC0) begin
            n_err++;
            $display("FAIL ignore_clear: seen=%b q=%h, required 1 c0", seen, bus.q);
        end
        bus.start = 1'b1; bus.mode = 3'd1; bus.d = 8'h5A;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.q !== 8'h5A || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_load: q=%h done=%b busy=%b, required 5a 1 0", bus.q, bus.done, bus.busy);
        end
    endtask

    task automatic test_amt_zero();
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 3'd3; bus.amt = 4'd0; bus.sin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.q !== 8'h5A || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL amt0: q=%h done=%b busy=%b, required 5a 1 0", bus.q, bus.done, bus.busy);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL amt0_after: done=%b busy=%b, required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_long_shl();
        do_load(8'hFF);
        run_shift("shl15", 3'd3, 4'd15, 1'b0, 8'hFF, 8'h00);
    endtask

    task automatic test_reset_mid();
        bit stray;
        do_load(8'hA5);
        bus.start = 1'b1; bus.mode = 3'd3; bus.amt = 4'd5; bus.sin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: q=%h busy=%b done=%b, required 00 0 0", bus.q, bus.busy, bus.done);
        end
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.q !== 8'h00) stray = 1;
        end
        n_cmp++;
        if (stray) begin
            n_err++;
            $display("FAIL rst_mid_after: stray=%b, required 0", stray);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_load();
        test_shl_steps();
        test_shr();
        test_asr_rot();
        test_back_to_back();
        test_amt_zero();
        test_long_shl();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal register: the successor to our fixed-width D-flip-flop register banks. It adds a WIDTH parameter, load, clear, logical/arithmetic shift and rotate modes, and multi-cycle shift-by-N commands under a start/busy/done handshake. It sits between datapath registers and serial I/O logic, serving as a general-purpose working register for the FPGA training designs.

## Interface
Parameters:
- WIDTH, 8, register width in bits (>= 2)
- AMT_W, 4, width of the shift-amount input

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  command strobe; sampled only while idle
- mode  input  3  operation: 0 hold, 1 load, 2 clear, 3 shl, 4 shr, 5 asr, 6 rotl, 7 rotr
- d  input  WIDTH  parallel load data
- amt  input  AMT_W  number of single-bit steps for modes 3-7
- sin  input  1  serial fill bit for shl (enters bit 0) and shr (enters bit WIDTH-1)
- q  output  WIDTH  register contents (registered)
- sout_l  output  1  q[WIDTH-1], combinational from q
- sout_r  output  1  q[0], combinational from q
- busy  output  1  high while a multi-step shift is in progress (registered)
- done  output  1  one-cycle completion pulse (registered)

## Operation
- FSM states: IDLE, SHIFT.
- Reset: q=0, busy=0, done=0, state IDLE, internal op/count cleared. Reset overrides everything, including mid-shift: the command is abandoned and no done pulse is generated.
- IDLE, start=0: q holds; done=0.
- IDLE, start=1 with mode 0/1/2: the operation executes on that edge (hold, q<=d, or q<=0). done=1 for the next cycle. busy stays 0.
- IDLE, start=1 with mode 3-7 and amt=0: q is unchanged; done=1 next cycle; busy stays 0.
- IDLE, start=1 with mode 3-7 and amt=N>0: mode and N are latched; go to SHIFT with busy=1. q is unchanged on this edge.
- SHIFT: each edge performs one step, and count decrements.
  - shl: q <= {q[WIDTH-2:0], sin}
  - shr: q <= {sin, q[WIDTH-1:1]}
  - asr: q <= {q[WIDTH-1], q[WIDTH-1:1]}
  - rotl: q <= {q[WIDTH-2:0], q[WIDTH-1]}
  - rotr: q <= {q[0], q[WIDTH-1:1]}
- sin is sampled live on every step, not latched at start.
- When count=1, the step is performed and the FSM returns to IDLE with busy=0 and done=1.
- start, mode, amt and d are ignored while busy=1; the latched command is unaffected by changes on them.
- N >= WIDTH is legal and steps continue literally. Example: rotl by WIDTH returns the original value; shl with sin=0 by N >= WIDTH gives 0.
- done is never high in the same cycle as busy.

## Timing
- Command accepted at edge t (start=1, IDLE).
- Modes 0-2, or amt=0: q is updated at edge t; done is high for the cycle after edge t only.
- Shift of N steps:
  - busy is high from after edge t until edge t+N.
  - Steps are applied at edges t+1 through t+N.
  - done is high for exactly one cycle after edge t+N.
  - Total latency from start to done is N+1 cycles.
- A new start may be sampled in the same cycle done is high; it is accepted, giving back-to-back commands.
- sout_l and sout_r follow q with zero added latency.

## Test plan
- Reset and load: assert rst for 2 cycles -> q=0x00, busy=0, done=0; then start, mode=1, d=0xA5 -> q=0xA5 next cycle, one-cycle done, busy never high.
- Logical shifts: q=0x81, shl amt=3 with sin=1 -> busy high for 3 cycles, q steps 0x03, 0x07, 0x0F, then done pulse. Repeat with shr amt=2, sin=0 from 0x81 -> 0x40, 0x20.
- Arithmetic shift and rotates: q=0x90, asr amt=2 -> 0xE4. q=0x81, rotl amt=8 -> 0x81. q=0x81, rotr amt=1 -> 0xC0.
- Handshake: during a shl amt=4, pulse start with mode=2 -> ignored, and q is not cleared. Then issue start in the done cycle -> the new command is accepted immediately.
- Boundaries: amt=0 with mode=3 -> q unchanged, done after 1 cycle, busy=0. amt=15 shl with sin=0 from 0xFF -> 0x00, 15 busy cycles, then done.
- Reset mid-operation: assert rst in the 2nd cycle of a shl amt=5 -> next cycle q=0, busy=0, and no done pulse follows.
